up_cu_gen2: RTL and testbench
=============================

Name: up_cu_gen2

Overview:
Parametrised second-generation control unit for the accumulator microprocessor. It runs the FETCH/DECODE/EXECUTE state machine and drives the datapath control strobes. Over the first-generation CU it adds:
- a wider opcode field and extra instructions (AND, JC, CALL, RET, NOP)
- a MemReq/MemRdy memory handshake with a wait-state timeout
- call-depth tracking with overflow/underflow fault
It sits between the instruction register/status flags and the datapath/memory interface.

Parameters:
OPW, 4, opcode width taken from the IR top bits; must be >= 4; opcodes above 12 are illegal.
SDEPTH, 4, maximum nested CALL depth; the return stack lives in the datapath.
WAITMAX, 15, maximum wait cycles on MemRdy before a timeout fault.

Ports:
CLOCK  in  1  system clock, rising edge.
RESET_N  in  1  asynchronous, active-low reset.
IR  in  OPW  opcode bits of the instruction register.
Aeq0  in  1  accumulator == 0.
Apos  in  1  accumulator > 0.
Cout  in  1  ALU carry flag, registered in the datapath.
Enter  in  1  user input strobe.
MemRdy  in  1  memory acknowledge for the current request.
Step  in  1  single-step pulse; present only with the optional feature.
IRload, PCload, JMPmux, Meminst, MemWr, MemReq, Aload, Halt  out  1 each  datapath/memory strobes.
Asel  out  2  accumulator source: 00 ALU, 01 input, 10 memory.
AluOp  out  2  ALU operation: 00 add, 01 sub, 10 and, 11 pass.
SPpush, SPpop, RetSel  out  1 each  return-stack control; RetSel selects the stack top into PC.
Depth  out  clog2(SDEPTH+1)  current call depth (registered).
Fault  out  1  sticky fault flag (registered).

Behaviour:
- Registered state: state, wait counter wcnt, Depth, Fault. Strobes are combinational from state and current inputs.
- On RESET_N=0 (asynchronous, takes effect mid-operation): state=START, wcnt=0, Depth=0, Fault=0. All strobes are 0 in START.
- Opcode map: 0 LOAD, 1 STORE, 2 ADD, 3 SUB, 4 INPUT, 5 JZ, 6 JPOS, 7 HALT, 8 AND, 9 JC, 10 CALL, 11 RET, 12 NOP, >=13 ILLEGAL.
- States: START, FETCH, DECODE, MEMOP, INPUT, JUMP, CALL, RET, NOP, HALT.
- START: for 1 cycle, then -> FETCH.
- FETCH: MemReq=1, Meminst=0. IRload=PCload=1 only in the cycle MemRdy=1, then -> DECODE.
- DECODE: Meminst=1 for 1 cycle, then branch on IR:
  - LOAD/STORE/ADD/SUB/AND -> MEMOP
  - INPUT -> INPUT
  - JZ/JPOS/JC -> JUMP
  - CALL -> CALL
  - RET -> RET
  - NOP -> NOP
  - HALT -> HALT
  - ILLEGAL -> HALT with Fault set.
- MEMOP: MemReq=Meminst=1 held until MemRdy.
  - STORE: MemWr=1 for the whole request.
  - In the MemRdy cycle: Aload=1 for LOAD/ADD/SUB/AND, with Asel=10 for LOAD and Asel=00 otherwise.
  - AluOp: 00 for ADD, 01 for SUB, 10 for AND, 11 for LOAD.
  - Then -> START.
- Wait rule (FETCH and MEMOP):
  - wcnt increments each cycle MemRdy=0 and clears on state exit.
  - If wcnt==WAITMAX with MemRdy=0: Fault=1, -> HALT, no load strobes.
  - MemRdy=1 in that same cycle wins; no fault.
- INPUT: Asel=01. Aload=1 only in cycles Enter=1, then -> START; otherwise stay.
- JUMP: JMPmux=1 for 1 cycle; PCload equals the Aeq0, Apos or Cout flag selected by the opcode. Then -> START.
- CALL: for 1 cycle.
  - Depth==SDEPTH: Fault=1, -> HALT, no push.
  - Otherwise SPpush=PCload=JMPmux=1, Depth+1, -> START.
- RET: for 1 cycle.
  - Depth==0: Fault=1, -> HALT.
  - Otherwise SPpop=PCload=RetSel=1, Depth-1, -> START.
- NOP: 1 cycle, no strobes.
- HALT: Halt=1 forever; only reset exits. Fault is sticky until reset.
- Latency with zero wait states:
  - non-memory instruction: 4 cycles, START to the next START;
  - MEMOP: 4 + waits;
  - FETCH: adds 1 cycle per MemRdy-low cycle.
- Out-of-range state encodings -> START.

Optional Feature:
UP_CU_SINGLE_STEP_EN:
- Defined: the Step port exists. START holds until Step=1 is sampled; a Step held high runs one instruction per START visit. Halt and Fault behaviour is unchanged.
- Undefined: the Step port is absent and START lasts exactly 1 cycle.

Test Plan:
- Reset mid-MEMOP (STORE, MemRdy=0) -> state=START, MemWr=0, Depth=0 within the same cycle RESET_N falls.
- FETCH with MemRdy low 3 cycles then high -> IRload=PCload=1 only in cycle 4; ADD completes 3 cycles later; AluOp=00.
- MemRdy held 0 in MEMOP, WAITMAX=15 -> Fault=1 after 16 MEMOP cycles, Halt=1 next cycle, Aload never asserted.
- SDEPTH=2: CALL, CALL, CALL -> Depth 1, 2, then Fault=1 and Halt=1 with no third SPpush. Separately, after reset: RET -> Fault=1.
- JC with Cout=1 -> PCload=JMPmux=1. JZ with Aeq0=0 -> JMPmux=1, PCload=0. IR=14 -> Fault=1 and Halt.
- With UP_CU_SINGLE_STEP_EN defined: hold Step=0 for 10 cycles -> stays in START, no MemReq; pulse Step -> exactly one instruction executes.

Source files
------------

// File: rtl/up_cu_gen2.sv
// Second-generation accumulator CPU control unit: FETCH/DECODE/EXECUTE sequencing,
// MemReq/MemRdy handshake with wait timeout, call-depth tracking and a sticky fault.
// Optional single-step mode: define UP_CU_SINGLE_STEP_EN to add the Step port.
module up_cu_gen2 #(
   parameter int unsigned OPW     = 4,
   parameter int unsigned SDEPTH  = 4,
   parameter int unsigned WAITMAX = 15
) (
   input  logic                             CLOCK,
   input  logic                             RESET_N,
   input  logic [OPW-1:0]                   IR,
   input  logic                             Aeq0,
   input  logic                             Apos,
   input  logic                             Cout,
   input  logic                             Enter,
   input  logic                             MemRdy,
`ifdef UP_CU_SINGLE_STEP_EN
   input  logic                             Step,
`endif
   output logic                             IRload,
   output logic                             PCload,
   output logic                             JMPmux,
   output logic                             Meminst,
   output logic                             MemWr,
   output logic                             MemReq,
   output logic                             Aload,
   output logic                             Halt,
   output logic [1:0]                       Asel,
   output logic [1:0]                       AluOp,
   output logic                             SPpush,
   output logic                             SPpop,
   output logic                             RetSel,
   output logic [$clog2(SDEPTH+1)-1:0]      Depth,
   output logic                             Fault
);

   localparam int unsigned DW = $clog2(SDEPTH + 1);
   localparam int unsigned WW = (WAITMAX < 1) ? 1 : $clog2(WAITMAX + 1);

   localparam logic [OPW-1:0] OP_LOAD  = OPW'(0);
   localparam logic [OPW-1:0] OP_STORE = OPW'(1);
   localparam logic [OPW-1:0] OP_ADD   = OPW'(2);
   localparam logic [OPW-1:0] OP_SUB   = OPW'(3);
   localparam logic [OPW-1:0] OP_INPUT = OPW'(4);
   localparam logic [OPW-1:0] OP_JZ    = OPW'(5);
   localparam logic [OPW-1:0] OP_JPOS  = OPW'(6);
   localparam logic [OPW-1:0] OP_HALT  = OPW'(7);
   localparam logic [OPW-1:0] OP_AND   = OPW'(8);
   localparam logic [OPW-1:0] OP_JC    = OPW'(9);
   localparam logic [OPW-1:0] OP_CALL  = OPW'(10);
   localparam logic [OPW-1:0] OP_RET   = OPW'(11);
   localparam logic [OPW-1:0] OP_NOP   = OPW'(12);

   typedef enum logic [3:0] {
      S_START, S_FETCH, S_DECODE, S_MEMOP, S_INPUT,
      S_JUMP, S_CALL, S_RET, S_NOP, S_HALT
   } state_t;

   state_t          state_q, state_d;
   logic [WW-1:0]   wcnt_q, wcnt_d;
   logic [DW-1:0]   depth_q, depth_d;
   logic            fault_q, fault_d;
   logic            wait_to_c;
   logic            acc_op_c;

   assign wait_to_c = (wcnt_q == WW'(WAITMAX));
   assign acc_op_c  = (IR == OP_LOAD) || (IR == OP_ADD) || (IR == OP_SUB) || (IR == OP_AND);

   // State register and control-unit status flops
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_START;
         wcnt_q  <= '0;
         depth_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         depth_q <= depth_d;
         fault_q <= fault_d;
      end
   end

   // Next state and datapath strobes; wcnt clears whenever a wait ends or the state is left
   always_comb begin
      state_d = state_q;
      wcnt_d  = '0;
      depth_d = depth_q;
      fault_d = fault_q;
      IRload  = 1'b0;
      PCload  = 1'b0;
      JMPmux  = 1'b0;
      Meminst = 1'b0;
      MemWr   = 1'b0;
      MemReq  = 1'b0;
      Aload   = 1'b0;
      Halt    = 1'b0;
      Asel    = 2'b00;
      AluOp   = 2'b00;
      SPpush  = 1'b0;
      SPpop   = 1'b0;
      RetSel  = 1'b0;
      case (state_q)
         S_START: begin
`ifdef UP_CU_SINGLE_STEP_EN
            if (Step) state_d = S_FETCH;
`else
            state_d = S_FETCH;
`endif
         end
         S_FETCH: begin
            MemReq = 1'b1;
            if (MemRdy) begin
               IRload  = 1'b1;
               PCload  = 1'b1;
               state_d = S_DECODE;
            end else if (wait_to_c) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               wcnt_d = wcnt_q + WW'(1);
            end
         end
         S_DECODE: begin
            Meminst = 1'b1;
            case (IR)
               OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND: state_d = S_MEMOP;
               OP_INPUT:                                  state_d = S_INPUT;
               OP_JZ, OP_JPOS, OP_JC:                     state_d = S_JUMP;
               OP_CALL:                                   state_d = S_CALL;
               OP_RET:                                    state_d = S_RET;
               OP_NOP:                                    state_d = S_NOP;
               OP_HALT:                                   state_d = S_HALT;
               default: begin
                  fault_d = 1'b1;
                  state_d = S_HALT;
               end
            endcase
         end
         S_MEMOP: begin
            MemReq  = 1'b1;
            Meminst = 1'b1;
            MemWr   = (IR == OP_STORE);
            if (IR == OP_LOAD) begin
               Asel  = 2'b10;
               AluOp = 2'b11;
            end else if (IR == OP_SUB) begin
               AluOp = 2'b01;
            end else if (IR == OP_AND) begin
               AluOp = 2'b10;
            end
            if (MemRdy) begin
               Aload   = acc_op_c;
               state_d = S_START;
            end else if (wait_to_c) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               wcnt_d = wcnt_q + WW'(1);
            end
         end
         S_INPUT: begin
            Asel = 2'b01;
            if (Enter) begin
               Aload   = 1'b1;
               state_d = S_START;
            end
         end
         S_JUMP: begin
            JMPmux = 1'b1;
            if (IR == OP_JZ)        PCload = Aeq0;
            else if (IR == OP_JPOS) PCload = Apos;
            else if (IR == OP_JC)   PCload = Cout;
            state_d = S_START;
         end
         S_CALL: begin
            if (depth_q == DW'(SDEPTH)) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               SPpush  = 1'b1;
               PCload  = 1'b1;
               JMPmux  = 1'b1;
               depth_d = depth_q + DW'(1);
               state_d = S_START;
            end
         end
         S_RET: begin
            if (depth_q == '0) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               SPpop   = 1'b1;
               PCload  = 1'b1;
               RetSel  = 1'b1;
               depth_d = depth_q - DW'(1);
               state_d = S_START;
            end
         end
         S_NOP:   state_d = S_START;
         S_HALT:  Halt = 1'b1;
         default: state_d = S_START;
      endcase
   end

   assign Depth = depth_q;
   assign Fault = fault_q;

endmodule

// File: tb/tb_up_cu_gen2.sv
// Scoreboard bench for up_cu_gen2: stimulus pushes hand-computed output vectors,
// a negedge monitor pops and compares them against the DUT each cycle.
module tb_up_cu_gen2;

   localparam int unsigned OPW     = 4;
   localparam int unsigned SDEPTH  = 2;
   localparam int unsigned WAITMAX = 15;

   localparam logic [17:0] IRL  = 18'h00001;
   localparam logic [17:0] PCL  = 18'h00002;
   localparam logic [17:0] JMP  = 18'h00004;
   localparam logic [17:0] MI   = 18'h00008;
   localparam logic [17:0] MW   = 18'h00010;
   localparam logic [17:0] MREQ = 18'h00020;
   localparam logic [17:0] AL   = 18'h00040;
   localparam logic [17:0] HLT  = 18'h00080;
   localparam logic [17:0] PUSH = 18'h00100;
   localparam logic [17:0] POP  = 18'h00200;
   localparam logic [17:0] RET  = 18'h00400;
   localparam logic [17:0] FLT  = 18'h20000;

   typedef struct {
      logic [17:0] e;
      string       tag;
   } exp_t;

   logic           CLOCK = 1'b0;
   logic           RESET_N = 1'b0;
   logic [OPW-1:0] IR = '0;
   logic           Aeq0 = 1'b0, Apos = 1'b0, Cout = 1'b0, Enter = 1'b0, MemRdy = 1'b0;
   logic           IRload, PCload, JMPmux, Meminst, MemWr, MemReq, Aload, Halt;
   logic [1:0]     Asel, AluOp;
   logic           SPpush, SPpop, RetSel;
   logic [1:0]     Depth;
   logic           Fault;
`ifdef UP_CU_SINGLE_STEP_EN
   logic           Step = 1'b0;
   logic           step_v = 1'b1;
`endif

   logic rst_v = 1'b0, aeq0_v = 1'b0, apos_v = 1'b0, cout_v = 1'b0, ent_v = 1'b0;
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [17:0] act;

   up_cu_gen2 #(.OPW(OPW), .SDEPTH(SDEPTH), .WAITMAX(WAITMAX)) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Cout(Cout),
      .Enter(Enter), .MemRdy(MemRdy),
`ifdef UP_CU_SINGLE_STEP_EN
      .Step(Step),
`endif
      .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux), .Meminst(Meminst), .MemWr(MemWr),
      .MemReq(MemReq), .Aload(Aload), .Halt(Halt), .Asel(Asel), .AluOp(AluOp),
      .SPpush(SPpush), .SPpop(SPpop), .RetSel(RetSel), .Depth(Depth), .Fault(Fault)
   );

   always #5 CLOCK = ~CLOCK;

   assign act = {Fault, Depth, AluOp, Asel, RetSel, SPpop, SPpush, Halt,
                 Aload, MemReq, MemWr, Meminst, JMPmux, PCload, IRload};

   function automatic logic [17:0] asl(input logic [1:0] v);
      return 18'(v) << 11;
   endfunction
   function automatic logic [17:0] alu(input logic [1:0] v);
      return 18'(v) << 13;
   endfunction
   function automatic logic [17:0] dep(input logic [1:0] v);
      return 18'(v) << 15;
   endfunction

   // Monitor: one expected vector per cycle, compared mid-cycle
   always @(negedge CLOCK) begin
      if (sb.size() != 0) begin
         exp_t x;
         x = sb.pop_front();
         n_tests++;
         if (act !== x.e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", x.tag, act, x.e, $time);
         end
      end
   end

   task automatic cyc(input string tag, input logic [3:0] ir, input logic rdy, input logic [17:0] e);
      exp_t x;
      @(posedge CLOCK);
      #1;
      RESET_N = rst_v;
      IR      = ir;
      MemRdy  = rdy;
      Aeq0    = aeq0_v;
      Apos    = apos_v;
      Cout    = cout_v;
      Enter   = ent_v;
`ifdef UP_CU_SINGLE_STEP_EN
      Step    = step_v;
`endif
      x.e   = e;
      x.tag = tag;
      sb.push_back(x);
   endtask

   task automatic fd(input string tag, input logic [3:0] ir, input logic [17:0] d);
      cyc({tag, "_fetch"}, ir, 1'b1, MREQ | IRL | PCL | d);
      cyc({tag, "_decode"}, ir, 1'b0, MI | d);
   endtask

   task automatic do_reset(input string tag);
      rst_v = 1'b0;
      cyc(tag, 4'd0, 1'b0, 18'h0);
      rst_v = 1'b1;
      cyc("reset_release", 4'd0, 1'b0, 18'h0);
   endtask

   initial begin
      rst_v = 1'b0;
      cyc("reset_state", 4'd0, 1'b0, 18'h0);
      cyc("reset_state", 4'd0, 1'b1, 18'h0);
      rst_v = 1'b1;
`ifdef UP_CU_SINGLE_STEP_EN
      step_v = 1'b0;
      cyc("step_release", 4'd0, 1'b0, 18'h0);
      repeat (9) cyc("step_hold", 4'd0, 1'b1, 18'h0);
      step_v = 1'b1;
      cyc("step_go", 4'd12, 1'b0, 18'h0);
      step_v = 1'b0;
      fd("step_nop", 4'd12, 18'h0);
      cyc("step_nop_ex", 4'd12, 1'b0, 18'h0);
      cyc("step_start", 4'd12, 1'b1, 18'h0);
      cyc("step_stay", 4'd12, 1'b1, 18'h0);
      step_v = 1'b1;
      cyc("step_go2", 4'd12, 1'b0, 18'h0);
`else
      cyc("reset_release", 4'd0, 1'b0, 18'h0);
`endif
      // ADD with three FETCH wait states
      repeat (3) cyc("add_fetch_wait", 4'd2, 1'b0, MREQ);
      cyc("add_fetch_rdy", 4'd2, 1'b1, MREQ | IRL | PCL);
      cyc("add_decode", 4'd2, 1'b0, MI);
      cyc("add_ex", 4'd2, 1'b1, MREQ | MI | AL | alu(2'b00));
      cyc("add_start", 4'd2, 1'b0, 18'h0);
      fd("load", 4'd0, 18'h0);
      cyc("load_ex", 4'd0, 1'b1, MREQ | MI | AL | asl(2'b10) | alu(2'b11));
      cyc("load_start", 4'd0, 1'b0, 18'h0);
      fd("sub", 4'd3, 18'h0);
      cyc("sub_wait", 4'd3, 1'b0, MREQ | MI | alu(2'b01));
      cyc("sub_ex", 4'd3, 1'b1, MREQ | MI | AL | alu(2'b01));
      cyc("sub_start", 4'd3, 1'b0, 18'h0);
      fd("and", 4'd8, 18'h0);
      cyc("and_ex", 4'd8, 1'b1, MREQ | MI | AL | alu(2'b10));
      cyc("and_start", 4'd8, 1'b0, 18'h0);
      fd("input", 4'd4, 18'h0);
      cyc("input_wait", 4'd4, 1'b0, asl(2'b01));
      ent_v = 1'b1;
      cyc("input_load", 4'd4, 1'b0, asl(2'b01) | AL);
      ent_v = 1'b0;
      cyc("input_start", 4'd4, 1'b0, 18'h0);
      // Conditional jumps
      cout_v = 1'b1;
      fd("jc", 4'd9, 18'h0);
      cyc("jc_taken", 4'd9, 1'b0, JMP | PCL);
      cyc("jc_start", 4'd9, 1'b0, 18'h0);
      cout_v = 1'b0;
      fd("jz", 4'd5, 18'h0);
      cyc("jz_not_taken", 4'd5, 1'b0, JMP);
      cyc("jz_start", 4'd5, 1'b0, 18'h0);
      apos_v = 1'b1;
      fd("jpos", 4'd6, 18'h0);
      cyc("jpos_taken", 4'd6, 1'b0, JMP | PCL);
      cyc("jpos_start", 4'd6, 1'b0, 18'h0);
      apos_v = 1'b0;
      fd("nop", 4'd12, 18'h0);
      cyc("nop_ex", 4'd12, 1'b0, 18'h0);
      cyc("nop_start", 4'd12, 1'b0, 18'h0);
      // Call depth up to SDEPTH, then overflow
      fd("call1", 4'd10, dep(2'd0));
      cyc("call1_ex", 4'd10, 1'b0, PUSH | PCL | JMP | dep(2'd0));
      cyc("call1_start", 4'd10, 1'b0, dep(2'd1));
      fd("call2", 4'd10, dep(2'd1));
      cyc("call2_ex", 4'd10, 1'b0, PUSH | PCL | JMP | dep(2'd1));
      cyc("call2_start", 4'd10, 1'b0, dep(2'd2));
      fd("ret", 4'd11, dep(2'd2));
      cyc("ret_ex", 4'd11, 1'b0, POP | PCL | RET | dep(2'd2));
      cyc("ret_start", 4'd11, 1'b0, dep(2'd1));
      fd("call3", 4'd10, dep(2'd1));
      cyc("call3_ex", 4'd10, 1'b0, PUSH | PCL | JMP | dep(2'd1));
      cyc("call3_start", 4'd10, 1'b0, dep(2'd2));
      fd("call_ovf", 4'd10, dep(2'd2));
      cyc("call_ovf_ex", 4'd10, 1'b0, dep(2'd2));
      cyc("call_ovf_halt", 4'd10, 1'b0, HLT | FLT | dep(2'd2));
      cyc("call_ovf_hold", 4'd10, 1'b1, HLT | FLT | dep(2'd2));
      do_reset("reset_after_halt");
      fd("ret_unf", 4'd11, 18'h0);
      cyc("ret_unf_ex", 4'd11, 1'b0, 18'h0);
      cyc("ret_unf_halt", 4'd11, 1'b0, HLT | FLT);
      do_reset("reset_after_ret");
      fd("illegal", 4'd14, 18'h0);
      cyc("illegal_halt", 4'd14, 1'b0, HLT | FLT);
      do_reset("reset_after_illegal");
      // Asynchronous reset in the middle of a STORE request
      fd("pre_call", 4'd10, 18'h0);
      cyc("pre_call_ex", 4'd10, 1'b0, PUSH | PCL | JMP);
      cyc("pre_call_start", 4'd10, 1'b0, dep(2'd1));
      fd("store", 4'd1, dep(2'd1));
      repeat (2) cyc("store_wait", 4'd1, 1'b0, MREQ | MI | MW | dep(2'd1));
      do_reset("store_mid_reset");
      // MEMOP timeout, then MemRdy winning on the last allowed wait
      fd("mem_to", 4'd2, 18'h0);
      repeat (16) cyc("mem_to_wait", 4'd2, 1'b0, MREQ | MI);
      cyc("mem_to_halt", 4'd2, 1'b0, HLT | FLT);
      do_reset("reset_after_memto");
      fd("mem_edge", 4'd2, 18'h0);
      repeat (15) cyc("mem_edge_wait", 4'd2, 1'b0, MREQ | MI);
      cyc("mem_edge_rdy", 4'd2, 1'b1, MREQ | MI | AL);
      cyc("mem_edge_start", 4'd2, 1'b0, 18'h0);
      repeat (16) cyc("fetch_to_wait", 4'd0, 1'b0, MREQ);
      cyc("fetch_to_halt", 4'd0, 1'b0, HLT | FLT);
      do_reset("reset_final");

      for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge CLOCK);
      #1;
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expected vectors left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
